ext_port_arbiter: RTL
=====================

Name: ext_port_arbiter

Overview:
- Shares the core's single external access port (ext_valid/ext_ready, 32-bit address and data, 4-bit write strobe, instruction flag) between NUM_REQ requesters, e.g. the Wishbone host bridge and a logic-analyzer debug requester.
- Round-robin arbitration, one outstanding transaction at a time.
- Request fields are registered so they stay stable toward the core for the whole transaction.
- A watchdog returns an error response if the core never asserts ext_ready.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 255, maximum BUSY cycles before an error response. 0 disables the watchdog.

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester request. Held high until that requester's req_ready pulse.
- req_instruction  input  NUM_REQ  per-requester instruction-fetch flag.
- req_address  input  NUM_REQ*32  packed addresses. Requester i uses bits [32i+31:32i].
- req_write_data  input  NUM_REQ*32  packed write data.
- req_write_strobe  input  NUM_REQ*4  packed byte strobes. 0 means read.
- req_ready  output  NUM_REQ  one-cycle completion pulse, one-hot.
- req_read_data  output  32  shared response data. Valid only while a req_ready bit is high.
- req_error  output  1  shared. High with req_ready when the transaction timed out.
- ext_valid  output  1  request to core.
- ext_instruction  output  1  to core.
- ext_address  output  32  to core.
- ext_write_data  output  32  to core.
- ext_write_strobe  output  4  to core.
- ext_ready  input  1  core completion.
- ext_read_data  input  32  core read data. Sampled on the ext_ready cycle.

Behaviour:
- Clocking and reset: all state is on clk. On reset, every output is 0, FSM goes to IDLE, rr_ptr=0, timeout counter=0.
- Reset asserted in any state, including mid-BUSY, aborts the transaction without a response. The requester must re-issue.
- IDLE:
  - If any req_valid is set, grant the first set index at or after rr_ptr, searching upward modulo NUM_REQ.
  - Latch grant index g and g's instruction, address, write_data and write_strobe into registers.
  - Go to BUSY. ext_valid rises the next cycle.
  - If no req_valid is set, stay in IDLE.
- BUSY:
  - ext_valid=1 and ext_* driven from the latched fields. These do not change until BUSY exits.
  - Timeout counter increments each cycle.
  - On ext_ready=1: latch ext_read_data, set err=0, go to RESP. ext_valid is 0 from the next cycle.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with ext_ready=0: set read data to 32'h0, set err=1, go to RESP.
  - ext_ready and timeout in the same cycle: ready wins, err=0.
- RESP (one cycle):
  - req_ready[g]=1, req_read_data=latched data, req_error=err.
  - rr_ptr <= (g+1) mod NUM_REQ. Clear the counter. Go to IDLE.
- Requester protocol:
  - Request fields must stay stable while req_valid is high.
  - A requester's req_valid seen in IDLE after its ready pulse is a new request.
  - Dropping req_valid before ready is illegal. The arbiter ignores it and completes the latched transaction.
- Latency: req_valid sampled at cycle 0 → ext_valid at cycle 1. ext_ready at cycle k → req_ready at k+1. Minimum 3 cycles from request to response; the next grant is possible at k+2.
- Non-granted requesters see req_ready=0 and simply wait.
- Fairness: with all requesters asserted, grants rotate 0,1,…,NUM_REQ-1. No requester waits more than NUM_REQ-1 transactions.
- ext_ready while not in BUSY is ignored.

Decomposition:
- Package ext_bus_pkg:
  - EXT_ADDR_W=32, EXT_DATA_W=32, EXT_STRB_W=4.
  - Struct ext_req_t {instruction, address, write_data, write_strobe}.
  - Enum arb_state_t {IDLE, BUSY, RESP}.
- Sub-module rr_arbiter: combinational. Inputs are the request vector and rr_ptr; outputs are a one-hot grant and its index. Reusable for other shared ports.

Test Plan:
- Single read: req_valid=01, address 0x0000_1000, strobe 0; core asserts ext_ready 2 cycles after ext_valid with data 0xCAFE_F00D → ext_valid held exactly 3 cycles, ext_address=0x1000, req_ready=01 one cycle later with req_read_data=0xCAFE_F00D and req_error=0.
- Contention: both valid at reset with rr_ptr=0 → req0 served first, then req1. Both still asserted afterwards → req0 served third. ext_address switches only between transactions.
- Write pass-through: req1 writes 0x1234_5678 with strobe 4'b0011 to 0x20 → ext_write_data=0x1234_5678 and ext_write_strobe=0011 are held stable throughout BUSY.
- Timeout: TIMEOUT_CYCLES=8, ext_ready held 0 → ext_valid high exactly 8 cycles, then req_ready pulses with req_error=1 and req_read_data=0. A subsequent request is granted normally.
- Ready on the timeout cycle: ext_ready=1 in the 8th BUSY cycle with data 0xA5A5_A5A5 → req_error=0, req_read_data=0xA5A5_A5A5.
- Reset mid-BUSY: reset asserted on the 2nd BUSY cycle → next cycle ext_valid=0 and no req_ready pulse. After release with both valid, req0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/ext_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_bus_pkg
// Description : Shared types and widths for the core's external access port
//               and its requester-side arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package ext_bus_pkg;

    localparam int EXT_ADDR_W = 32;
    localparam int EXT_DATA_W = 32;
    localparam int EXT_STRB_W = 4;

    // One latched request as presented to the core.
    typedef struct packed {
        logic                  instruction;
        logic [EXT_ADDR_W-1:0] address;
        logic [EXT_DATA_W-1:0] write_data;
        logic [EXT_STRB_W-1:0] write_strobe;
    } ext_req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Width of an index into n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. Grants the first set
//               request at or after ptr, searching upward modulo NUM_REQ.
// Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import ext_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // Requester index reached by stepping off places up from base, wrapped.
    function automatic logic [IDX_W-1:0] rr_slot(input logic [IDX_W-1:0] base,
                                                 input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] w_slot;

    // Priority scan starting at ptr; the first hit wins and later hits are ignored.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_slot      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            w_slot = rr_slot(ptr, off);
            if (!grant_valid && req[w_slot]) begin
                grant_valid   = 1'b1;
                grant_idx     = w_slot;
                grant[w_slot] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ext_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ext_port_arbiter
// Description : Shares the core's single external access port between
//               NUM_REQ requesters with round-robin arbitration, one
//               transaction in flight, latched request fields and a
//               watchdog that answers with an error if the core stalls.
// Revision    : 1.0  initial release
// ============================================================================
module ext_port_arbiter
    import ext_bus_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_instruction,
    input  logic [NUM_REQ*EXT_ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*EXT_DATA_W-1:0] req_write_data,
    input  logic [NUM_REQ*EXT_STRB_W-1:0] req_write_strobe,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [EXT_DATA_W-1:0]         req_read_data,
    output logic                          req_error,
    output logic                          ext_valid,
    output logic                          ext_instruction,
    output logic [EXT_ADDR_W-1:0]         ext_address,
    output logic [EXT_DATA_W-1:0]         ext_write_data,
    output logic [EXT_STRB_W-1:0]         ext_write_strobe,
    input  logic                          ext_ready,
    input  logic [EXT_DATA_W-1:0]         ext_read_data
);

    localparam int                  c_idx_w    = idx_width(NUM_REQ);
    localparam int                  c_cnt_w    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [c_idx_w-1:0]  c_last_idx = c_idx_w'(NUM_REQ - 1);
    localparam logic [c_idx_w-1:0]  c_idx_one  = c_idx_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    // Last BUSY count before giving up; unused when the watchdog is off.
    localparam logic [c_cnt_w-1:0]  c_tmo_last = c_cnt_w'(TIMEOUT_CYCLES - 1);
    localparam logic                c_wdog_en  = (TIMEOUT_CYCLES != 0);

    ext_req_t              w_fields [NUM_REQ];
    ext_req_t              w_sel;
    logic [NUM_REQ-1:0]    w_grant;
    logic [c_idx_w-1:0]    w_grant_idx;
    logic                  w_grant_valid;
    logic [c_idx_w-1:0]    w_next_ptr;
    logic                  w_timeout;

    arb_state_t            r_state;
    logic [c_idx_w-1:0]    r_rr_ptr;
    logic [c_idx_w-1:0]    r_grant_idx;
    logic [NUM_REQ-1:0]    r_grant_oh;
    ext_req_t              r_req;
    logic                  r_ext_valid;
    logic [EXT_DATA_W-1:0] r_rdata;
    logic                  r_err;
    logic [NUM_REQ-1:0]    r_ready;
    logic [c_cnt_w-1:0]    r_cnt;

    // Slice the packed per-requester buses into one struct per requester.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_fields[gi] = {req_instruction[gi],
                               req_address[gi*EXT_ADDR_W +: EXT_ADDR_W],
                               req_write_data[gi*EXT_DATA_W +: EXT_DATA_W],
                               req_write_strobe[gi*EXT_STRB_W +: EXT_STRB_W]};
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_idx_w)
    ) u_rr_arbiter (
        .req         (req_valid),
        .ptr         (r_rr_ptr),
        .grant       (w_grant),
        .grant_idx   (w_grant_idx),
        .grant_valid (w_grant_valid)
    );

    assign w_sel      = w_fields[w_grant_idx];
    assign w_next_ptr = (r_grant_idx == c_last_idx) ? '0 : (r_grant_idx + c_idx_one);
    assign w_timeout  = c_wdog_en && (r_cnt == c_tmo_last);

    // Arbitration FSM: grant in IDLE, hold the core request in BUSY, pulse the
    // winner's ready in RESP. Response registers are cleared outside RESP so
    // the shared response bus reads zero between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_grant_oh  <= '0;
            r_req       <= '0;
            r_ext_valid <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_ready     <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_grant_idx <= w_grant_idx;
                        r_grant_oh  <= w_grant;
                        r_req       <= w_sel;
                        r_ext_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + c_cnt_one;
                    // A completion on the watchdog's last cycle still counts as success.
                    if (ext_ready) begin
                        r_rdata     <= ext_read_data;
                        r_err       <= 1'b0;
                        r_ready     <= r_grant_oh;
                        r_ext_valid <= 1'b0;
                        r_req       <= '0;
                        r_state     <= RESP;
                    end else if (w_timeout) begin
                        r_rdata     <= '0;
                        r_err       <= 1'b1;
                        r_ready     <= r_grant_oh;
                        r_ext_valid <= 1'b0;
                        r_req       <= '0;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_ready  <= '0;
                    r_rdata  <= '0;
                    r_err    <= 1'b0;
                    r_rr_ptr <= w_next_ptr;
                    r_cnt    <= '0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ext_valid        = r_ext_valid;
    assign ext_instruction  = r_req.instruction;
    assign ext_address      = r_req.address;
    assign ext_write_data   = r_req.write_data;
    assign ext_write_strobe = r_req.write_strobe;
    assign req_ready        = r_ready;
    assign req_read_data    = r_rdata;
    assign req_error        = r_err;

endmodule
`default_nettype wire
